// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID/EX pipeline register plus EX-stage operand resolution for a 64-bit ALU.
//   Takes decoded instructions from ID under a valid/ready handshake. It forwards
//   results from EX/MEM (fm_*) and MEM/WB (fw_*) onto the stored source operands.
//   It inserts one bubble per load-use hazard. While EX/MEM is stalled it keeps
//   the held instruction and refreshes its operands.
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  squash the EX slot (branch/trap)
//   id_*                   decoded instruction from ID; id_ready is the accept
//   fm_*, fw_*             forwarding sources (EX/MEM beats MEM/WB)
//   ex_ready               EX/MEM accepts the current EX instruction
//   ex_valid               EX slot holds a live instruction
//   alu_a, alu_b, alu_op   ALU operands and op code
//   ex_store_data          forwarded rs2 value for stores
//   ex_rd, ex_reg_write, ex_mem_read, ex_pc   registered control and PC
//   load_use_stall         load-use hazard detected this cycle
module id_ex_operand_stage #(
  parameter int XLEN = 64,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RAW-1:0]  id_rs1,
  input  logic [RAW-1:0]  id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_op,
  input  logic            id_src_pc,
  input  logic            id_src_imm,
  input  logic [RAW-1:0]  id_rd,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            fm_valid,
  input  logic [RAW-1:0]  fm_rd,
  input  logic [XLEN-1:0] fm_data,
  input  logic            fw_valid,
  input  logic [RAW-1:0]  fw_rd,
  input  logic [XLEN-1:0] fw_data,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RAW-1:0]  ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic [XLEN-1:0] ex_pc,
  output logic            load_use_stall
);

  localparam logic [3:0] OP_NOP = 4'b1111;

  logic            ex_valid_q,  ex_valid_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [RAW-1:0]  rs1_q,       rs1_d;
  logic [RAW-1:0]  rs2_q,       rs2_d;
  logic [XLEN-1:0] rs1_val_q,   rs1_val_d;
  logic [XLEN-1:0] rs2_val_q,   rs2_val_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  logic [3:0]      alu_op_q,    alu_op_d;
  logic            src_pc_q,    src_pc_d;
  logic            src_imm_q,   src_imm_d;
  logic [RAW-1:0]  rd_q,        rd_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q,  mem_read_d;

  logic            fm_hit1, fw_hit1, fm_hit2, fw_hit2;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic            stall;
  logic            ready;

  // Forwarding on the stored source indices; x0 is hard-wired and never forwarded.
  always_comb begin
    fm_hit1 = fm_valid && (fm_rd == rs1_q) && (rs1_q != '0);
    fw_hit1 = fw_valid && (fw_rd == rs1_q) && (rs1_q != '0);
    fm_hit2 = fm_valid && (fm_rd == rs2_q) && (rs2_q != '0);
    fw_hit2 = fw_valid && (fw_rd == rs2_q) && (rs2_q != '0);
    fwd_rs1 = fm_hit1 ? fm_data : (fw_hit1 ? fw_data : rs1_val_q);
    fwd_rs2 = fm_hit2 ? fm_data : (fw_hit2 ? fw_data : rs2_val_q);
  end

  // A load in EX cannot forward its data yet, so a dependent ID instruction waits.
  always_comb begin
    stall = ex_valid_q && mem_read_q && (rd_q != '0) && id_valid &&
            ((id_use_rs1 && (id_rs1 == rd_q)) || (id_use_rs2 && (id_rs2 == rd_q)));
    ready = (!ex_valid_q || ex_ready) && !stall && !flush;
  end

  always_comb begin
    ex_valid_d  = ex_valid_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    imm_d       = imm_q;
    alu_op_d    = alu_op_q;
    src_pc_d    = src_pc_q;
    src_imm_d   = src_imm_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (stall && ex_ready) begin
      ex_valid_d = 1'b0;              // bubble; ID keeps presenting the instruction
    end else if (ready && id_valid) begin
      ex_valid_d  = 1'b1;
      pc_d        = id_pc;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rs1_val_d   = id_rs1_val;
      rs2_val_d   = id_rs2_val;
      imm_d       = id_imm;
      alu_op_d    = id_alu_op;
      src_pc_d    = id_src_pc;
      src_imm_d   = id_src_imm;
      rd_d        = id_rd;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
    end else if (ready) begin
      ex_valid_d = 1'b0;
    end else begin
      // Held under downstream stall: capture forwarded values now, because the
      // producers may retire before EX/MEM takes this instruction.
      rs1_val_d = fwd_rs1;
      rs2_val_d = fwd_rs2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      imm_q       <= '0;
      alu_op_q    <= OP_NOP;
      src_pc_q    <= 1'b0;
      src_imm_q   <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      imm_q       <= imm_d;
      alu_op_q    <= alu_op_d;
      src_pc_q    <= src_pc_d;
      src_imm_q   <= src_imm_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  assign id_ready       = ready;
  assign load_use_stall = stall;
  assign ex_valid       = ex_valid_q;
  assign alu_a          = src_pc_q  ? pc_q  : fwd_rs1;
  assign alu_b          = src_imm_q ? imm_q : fwd_rs2;
  assign alu_op         = alu_op_q;
  assign ex_store_data  = fwd_rs2;
  assign ex_rd          = rd_q;
  assign ex_reg_write   = reg_write_q;
  assign ex_mem_read    = mem_read_q;
  assign ex_pc          = pc_q;

endmodule
